associative_buffer_arbiter: RTL and testbench
=============================================

ASSOCIATIVE_BUFFER_ARBITER -- requirements
Module: associative_buffer_arbiter

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, default 8, data word width; KEY_WIDTH, default 4, key width; LOOKUP_TIMEOUT, default 4, maximum lookup cycles (minimum 1).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- async_nreset  in  1  reset; synchronous, active-low.
- req_a, req_b  in  1  request from requester A / B.
- op_a, op_b  in  2  operation: 0 READ, 1 LOAD, 2 INCR, 3 CLR.
- key_a, key_b  in  KEY_WIDTH  key.
- wdata_a, wdata_b  in  DATA_WIDTH  write data (LOAD only).
- ack_a, ack_b  out  1  one-cycle completion pulse.
- rdata_a, rdata_b  out  DATA_WIDTH  read result; valid while ack is high.
- hit_a, hit_b  out  1  READ found the key; valid while ack is high.
- busy  out  1  high in every state except IDLE.
- buf_ctrl  out  2  buffer command: 0 NONE, 1 LOAD, 2 INCR, 3 CLR.
- buf_key  out  KEY_WIDTH  buffer key.
- buf_data  out  DATA_WIDTH  buffer write data.
- buf_rdata  in  DATA_WIDTH  buffer read data.
- buf_valid  in  1  buffer read data valid.

Function
REQ-003 The block SHALL implement the FSM states IDLE, ISSUE, LOOKUP and DONE.
REQ-004 In IDLE, when at least one req is high on a rising edge, the block SHALL grant one requester, latch that requester's op, key and wdata, and go to ISSUE.
REQ-005 When only one req is high, that requester SHALL be granted.
REQ-006 When both reqs are high, the requester named by the round-robin pointer SHALL be granted.
REQ-007 The round-robin pointer SHALL point to the non-served requester after every completed transaction.
REQ-008 req SHALL be sampled only in IDLE; req changes in other states SHALL have no effect.
REQ-009 In ISSUE, the block SHALL drive buf_ctrl with the latched op (NONE for READ) for exactly one cycle, with buf_key and buf_data equal to the latched values.
REQ-010 From ISSUE, LOAD, INCR and CLR SHALL go to DONE, and READ SHALL go to LOOKUP.
REQ-011 In LOOKUP:
- buf_ctrl SHALL be NONE and buf_key SHALL hold the latched key.
- A cycle counter SHALL start at 0 on entry and increment every LOOKUP cycle.
REQ-012 If buf_valid is 1 in a LOOKUP cycle, the block SHALL capture buf_rdata, set hit=1 and go to DONE.
REQ-013 If buf_valid stays 0 for LOOKUP_TIMEOUT LOOKUP cycles, the block SHALL set rdata=0 and hit=0 and go to DONE.
REQ-014 When buf_valid is 1 in the final LOOKUP cycle, the hit outcome SHALL take priority over the timeout.
REQ-015 In DONE, the block SHALL assert exactly the granted requester's ack for one cycle, update the pointer, and return to IDLE.
REQ-016 rdata_x and hit_x SHALL be 0 whenever ack_x is 0.
REQ-017 For LOAD, INCR and CLR, hit SHALL be 0.
REQ-018 Write latency SHALL be 2 cycles: req sampled in IDLE at cycle k, ISSUE at k+1, ack at k+2.
REQ-019 Read latency SHALL be ack at k+3+m when buf_valid is first seen in LOOKUP cycle m (0-based).
REQ-020 A read that times out SHALL be acked at k+2+LOOKUP_TIMEOUT.
REQ-021 A requester SHALL hold req, op, key and wdata stable until its ack, and SHALL drop req in the cycle after ack; a req still high in that cycle is a new request.
REQ-022 Outside ISSUE, buf_ctrl SHALL be NONE.
REQ-023 buf_ctrl SHALL never carry two commands in consecutive cycles.

Reset
REQ-024 While async_nreset is 0 at a rising edge, the block SHALL set:
- state = IDLE;
- pointer = A;
- LOOKUP counter = 0;
- ack_a, ack_b, hit_a, hit_b = 0;
- rdata_a, rdata_b = 0;
- busy = 0;
- buf_ctrl = NONE;
- buf_key, buf_data = 0.
REQ-025 A reset in any state SHALL abort the transaction in flight without issuing an ack.
REQ-026 If a reset occurs during ISSUE, buf_ctrl SHALL be NONE from the following cycle.

Verification
REQ-027 Single write: req_a with LOAD, key 4'h1, wdata 8'h0F -> buf_ctrl=1, buf_key=1, buf_data=8'h0F for one cycle; ack_a two cycles after the request; hit_a=0.
REQ-028 Contention: req_a and req_b both high with LOAD after reset -> A served first, then B; buf_ctrl pulses in separate cycles; ack_a precedes ack_b; a second simultaneous pair is served B first.
REQ-029 Read hit: req_b with READ, key 4'h8; bench drives buf_valid=1, buf_rdata=8'hDB in LOOKUP cycle 1 -> ack_b at k+4, rdata_b=8'hDB, hit_b=1.
REQ-030 Read miss/timeout: READ with buf_valid held 0 and LOOKUP_TIMEOUT=4 -> ack at k+6, rdata=0, hit=0; buf_ctrl stays NONE throughout.
REQ-031 Reset mid-LOOKUP: async_nreset=0 for one edge during LOOKUP -> no ack; busy=0 next cycle; pointer=A.
REQ-032 Boundary: buf_valid=1 in the final timeout cycle -> hit=1 with the captured data.

Source files
------------

// File: rtl/associative_buffer_arbiter.sv
// Two-requester arbiter in front of an associative buffer.
// One transaction at a time: grant in IDLE, one command cycle in ISSUE,
// an optional bounded wait for read data in LOOKUP, and a one-cycle ack in DONE.
// Handshake: a requester raises req with stable op/key/wdata, keeps them
// stable until its ack pulse, and drops req in the cycle after the ack.
module associative_buffer_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int KEY_WIDTH      = 4,
   parameter int LOOKUP_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  async_nreset,
   input  logic                  req_a,
   input  logic                  req_b,
   input  logic [1:0]            op_a,
   input  logic [1:0]            op_b,
   input  logic [KEY_WIDTH-1:0]  key_a,
   input  logic [KEY_WIDTH-1:0]  key_b,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  ack_a,
   output logic                  ack_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  hit_a,
   output logic                  hit_b,
   output logic                  busy,
   output logic [1:0]            buf_ctrl,
   output logic [KEY_WIDTH-1:0]  buf_key,
   output logic [DATA_WIDTH-1:0] buf_data,
   input  logic [DATA_WIDTH-1:0] buf_rdata,
   input  logic                  buf_valid
);

   typedef enum logic [1:0] {IDLE, ISSUE, LOOKUP, DONE} state_t;

   localparam int CW = (LOOKUP_TIMEOUT > 1) ? $clog2(LOOKUP_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LOOKUP_TIMEOUT - 1);
   localparam logic [1:0] OP_READ = 2'd0;

   state_t                state_r, state_nxt;
   logic                  ptr_r;     // 0 = A wins a tie, 1 = B wins a tie
   logic                  grant_r;   // 0 = A, 1 = B
   logic                  grant_nxt;
   logic [1:0]            op_r;
   logic [KEY_WIDTH-1:0]  key_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  hit_r;
   logic [CW-1:0]         cnt_r;

   // Arbitration: a lone request wins; a tie goes to the round-robin pointer.
   always_comb begin
      grant_nxt = 1'b0;
      if (req_a && req_b) grant_nxt = ptr_r;
      else                grant_nxt = req_b;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!async_nreset) state_r <= IDLE;
      else               state_r <= state_nxt;
   end

   // Next state and buffer-side outputs. READ encodes as NONE on buf_ctrl,
   // so the latched op can be driven straight through in ISSUE.
   always_comb begin
      state_nxt = state_r;
      busy      = 1'b1;
      buf_ctrl  = 2'd0;
      buf_key   = '0;
      buf_data  = '0;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
            if (req_a || req_b) state_nxt = ISSUE;
         end
         ISSUE: begin
            buf_ctrl  = op_r;
            buf_key   = key_r;
            buf_data  = wdata_r;
            state_nxt = (op_r == OP_READ) ? LOOKUP : DONE;
         end
         LOOKUP: begin
            buf_key = key_r;
            if (buf_valid || (cnt_r == CNT_LAST)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction datapath: latch the winner, count LOOKUP cycles, capture read data,
   // and move the pointer to the other requester when a transaction completes.
   always_ff @(posedge clk) begin
      if (!async_nreset) begin
         ptr_r   <= 1'b0;
         grant_r <= 1'b0;
         op_r    <= '0;
         key_r   <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
         hit_r   <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_a || req_b) begin
                  grant_r <= grant_nxt;
                  op_r    <= grant_nxt ? op_b    : op_a;
                  key_r   <= grant_nxt ? key_b   : key_a;
                  wdata_r <= grant_nxt ? wdata_b : wdata_a;
                  rdata_r <= '0;
                  hit_r   <= 1'b0;
               end
            end
            ISSUE: cnt_r <= '0;
            LOOKUP: begin
               cnt_r <= cnt_r + 1'b1;
               if (buf_valid) begin
                  rdata_r <= buf_rdata;
                  hit_r   <= 1'b1;
               end
            end
            DONE: begin
               ptr_r <= ~grant_r;
               cnt_r <= '0;
            end
            default: cnt_r <= '0;
         endcase
      end
   end

   assign ack_a   = (state_r == DONE) && !grant_r;
   assign ack_b   = (state_r == DONE) &&  grant_r;
   assign rdata_a = ack_a ? rdata_r : '0;
   assign rdata_b = ack_b ? rdata_r : '0;
   assign hit_a   = ack_a && hit_r;
   assign hit_b   = ack_b && hit_r;

endmodule

// File: tb/tb_associative_buffer_arbiter.sv
// Bench for associative_buffer_arbiter: directed scenarios plus randomized
// traffic, checked against a transaction-level model of grant order,
// latency and read outcome.
module tb_associative_buffer_arbiter;

   localparam int DW = 8;
   localparam int KW = 4;
   localparam int T  = 4;

   logic          clk = 1'b0;
   logic          async_nreset;
   logic          req_a, req_b;
   logic [1:0]    op_a, op_b;
   logic [KW-1:0] key_a, key_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic          ack_a, ack_b, hit_a, hit_b, busy;
   logic [DW-1:0] rdata_a, rdata_b;
   logic [1:0]    buf_ctrl;
   logic [KW-1:0] buf_key;
   logic [DW-1:0] buf_data;
   logic [DW-1:0] buf_rdata;
   logic          buf_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Requester model: pending request per side (0 = A, 1 = B) and the pointer.
   bit            pend[2];
   logic [1:0]    p_op[2];
   logic [KW-1:0] p_key[2];
   logic [DW-1:0] p_wd[2];
   int            ptr_m;

   associative_buffer_arbiter #(
      .DATA_WIDTH(DW), .KEY_WIDTH(KW), .LOOKUP_TIMEOUT(T)
   ) dut (
      .clk(clk), .async_nreset(async_nreset),
      .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
      .key_a(key_a), .key_b(key_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .hit_a(hit_a), .hit_b(hit_b), .busy(busy),
      .buf_ctrl(buf_ctrl), .buf_key(buf_key), .buf_data(buf_data),
      .buf_rdata(buf_rdata), .buf_valid(buf_valid)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_reqs();
      req_a = pend[0]; op_a = p_op[0]; key_a = p_key[0]; wdata_a = p_wd[0];
      req_b = pend[1]; op_b = p_op[1]; key_b = p_key[1]; wdata_b = p_wd[1];
   endtask

   task automatic new_req(input int i, input int op, input int key, input int wd);
      pend[i]  = 1'b1;
      p_op[i]  = (op  < 0) ? 2'($urandom_range(0, 3))   : 2'(op);
      p_key[i] = (key < 0) ? KW'($urandom_range(0, 15)) : KW'(key);
      p_wd[i]  = (wd  < 0) ? DW'($urandom)              : DW'(wd);
   endtask

   // Runs one transaction starting at the falling edge of an IDLE cycle.
   // mv_force: LOOKUP cycle in which buf_valid is shown (>= T means never, -1 random).
   // rd_force: data shown with buf_valid (-1 random). allow_new: idle side may request mid-flight.
   task automatic run_txn(input int mv_force, input int rd_force, input bit allow_new);
      int            g, o, mv, n_ack;
      logic [1:0]    op;
      logic [KW-1:0] key;
      logic [DW-1:0] wd, cap;
      bit            exp_hit, done;
      g     = (pend[0] && pend[1]) ? ptr_m : (pend[1] ? 1 : 0);
      o     = 1 - g;
      mv    = (mv_force >= 0) ? mv_force : $urandom_range(0, T + 1);
      op    = p_op[g];
      key   = p_key[g];
      wd    = p_wd[g];
      n_ack = (op != 2'd0) ? 2 : ((mv < T) ? 3 + mv : 2 + T);
      exp_hit = (op == 2'd0) && (mv < T);
      cap   = '0;
      done  = 1'b0;
      drive_reqs();
      buf_valid = 1'b0;
      check("idle_busy", 32'(busy), 32'd0);
      for (int n = 1; n <= n_ack + 3 && !done; n++) begin
         @(posedge clk);
         @(negedge clk);
         check("buf_ctrl", 32'(buf_ctrl), (n == 1) ? 32'(op) : 32'd0);
         check("buf_key", 32'(buf_key),
               (n == 1 || (op == 2'd0 && n < n_ack)) ? 32'(key) : 32'd0);
         check("buf_data", 32'(buf_data), (n == 1) ? 32'(wd) : 32'd0);
         check("busy", 32'(busy), 32'd1);
         if (ack_a || ack_b) begin
            done = 1'b1;
            check("ack_cycle", 32'(n), 32'(n_ack));
            check("ack_which", {30'd0, ack_b, ack_a}, (g == 0) ? 32'd1 : 32'd2);
            check("rdata", 32'(g == 0 ? rdata_a : rdata_b), exp_hit ? 32'(cap) : 32'd0);
            check("hit", 32'(g == 0 ? hit_a : hit_b), 32'(exp_hit));
            check("other_quiet", 32'(g == 0 ? {rdata_b, hit_b} : {rdata_a, hit_a}), 32'd0);
            pend[g] = 1'b0;
            ptr_m   = o;
            buf_valid = 1'b0;
         end else begin
            check("no_ack_out", {14'd0, rdata_a, rdata_b, hit_a, hit_b}, 32'd0);
            buf_rdata = (rd_force >= 0) ? DW'(rd_force) : DW'($urandom);
            if (op == 2'd0) buf_valid = (n >= 2) && (n - 2 == mv);
            else            buf_valid = 1'($urandom_range(0, 1));
            if (op == 2'd0 && n >= 2 && n - 2 == mv) cap = buf_rdata;
         end
         if (allow_new && !pend[o] && $urandom_range(0, 3) == 0) new_req(o, -1, -1, -1);
         drive_reqs();
      end
      check("ack_seen", 32'(done), 32'd1);
      if (!done) pend[g] = 1'b0;
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int r;
      pend[0] = 1'b0; pend[1] = 1'b0;
      p_op[0] = '0; p_op[1] = '0; p_key[0] = '0; p_key[1] = '0; p_wd[0] = '0; p_wd[1] = '0;
      ptr_m = 0;
      async_nreset = 1'b0;
      drive_reqs();
      buf_rdata = '0;
      buf_valid = 1'b0;

      // Reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", {30'd0, ack_a, ack_b}, 32'd0);
      check("rst_hit", {30'd0, hit_a, hit_b}, 32'd0);
      check("rst_rdata", {16'd0, rdata_a, rdata_b}, 32'd0);
      check("rst_buf_ctrl", 32'(buf_ctrl), 32'd0);
      check("rst_buf_kd", {20'd0, buf_key, buf_data}, 32'd0);
      async_nreset = 1'b1;

      // Contention after reset: A first; A re-requests at once so the next pair goes to B.
      new_req(0, 1, 2, 8'h11);
      new_req(1, 1, 3, 8'h22);
      run_txn(-1, -1, 1'b0);
      new_req(0, 1, 5, 8'h33);
      run_txn(-1, -1, 1'b0);
      run_txn(-1, -1, 1'b0);

      // Single write, then read hit in LOOKUP cycle 1, timeout, and final-cycle hit.
      new_req(0, 1, 4'h1, 8'h0F);
      run_txn(-1, -1, 1'b0);
      new_req(1, 0, 4'h8, 0);
      run_txn(1, 8'hDB, 1'b0);
      new_req(0, 0, 4'h6, 0);
      run_txn(T + 1, -1, 1'b0);
      new_req(1, 0, 4'h9, 0);
      run_txn(T - 1, 8'h5A, 1'b0);
      new_req(0, 2, 4'h7, 0);
      run_txn(-1, -1, 1'b0);
      new_req(1, 3, 4'h7, 0);
      run_txn(-1, -1, 1'b0);

      // Reset mid-LOOKUP after an A write (pointer then at B): no ack, pointer back to A.
      new_req(0, 1, 4'h2, 8'h44);
      run_txn(-1, -1, 1'b0);
      new_req(0, 0, 4'h3, 0);
      drive_reqs();
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_rst_key", 32'(buf_key), 32'h3);
      async_nreset = 1'b0;
      pend[0] = 1'b0;
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
      async_nreset = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_buf", {22'd0, buf_ctrl, buf_key, 4'd0}, 32'd0);
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         check("midrst_no_ack", {29'd0, ack_a, ack_b, busy}, 32'd0);
      end
      ptr_m = 0;
      new_req(0, 1, 4'hA, 8'h55);
      new_req(1, 1, 4'hB, 8'h66);
      run_txn(-1, -1, 1'b0);
      run_txn(-1, -1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         if (!pend[0] && !pend[1]) begin
            r = $urandom_range(1, 3);
            if (r != 2) new_req(0, -1, -1, -1);
            if (r != 1) new_req(1, -1, -1, -1);
         end
         run_txn(-1, -1, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
